// File: rtl/regfile_pkg.sv
// Shared constants, the read-address type and the clog2 helper for the
// parametrised register file.
package regfile_pkg;

    localparam int ALT_IDX_DEF  = 11;
    localparam int MEMD_IDX_DEF = 12;
    localparam int CTRL_IDX_DEF = 13;

    localparam int N_MIN   = 2;
    localparam int N_MAX   = 64;
    localparam int NRD_MAX = 4;

    // Wide enough to hold N_MAX itself, so range compares never truncate.
    localparam int RADDR_W = 7;
    typedef logic [RADDR_W-1:0] raddr_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Datapath-side bus of the register file: write sources, enables, context
// controls, indexed read ports and the live register outputs.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int W   = 8,
    parameter int N   = 16,
    parameter int NRD = 2,
    parameter int AW  = clog2(N)
) ();

    logic [W-1:0]            d;
    logic [W-1:0]            alt_d;
    logic [N-1:0]            en_n;
    logic [NRD-1:0][AW-1:0]  raddr;
    logic [NRD-1:0][W-1:0]   rdata;
    logic [N-1:0][W-1:0]     q;
    logic [W-1:0]            ctrl;
    logic [W-1:0]            memd_top;
    logic                    save_n;
    logic                    restore_n;
    logic                    ctrl_upd;

    modport master (
        output d, alt_d, en_n, raddr, save_n, restore_n,
        input  rdata, q, ctrl, memd_top, ctrl_upd
    );

    modport slave (
        input  d, alt_d, en_n, raddr, save_n, restore_n,
        output rdata, q, ctrl, memd_top, ctrl_upd
    );

endinterface

// File: rtl/regfile_cell.sv
// One register slot: a live register plus its shadow copy.
// Write beats restore; save always captures the pre-edge live value.
module regfile_cell #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_n,
    input  logic [W-1:0] wdata,
    input  logic         save_n,
    input  logic         restore_n,
    output logic [W-1:0] live
);

    logic [W-1:0] live_q, live_d;
    logic [W-1:0] shadow_q, shadow_d;

    always_comb begin
        live_d = live_q;
        if (!wr_n) begin
            live_d = wdata;
        end else if (!restore_n) begin
            live_d = shadow_q;
        end
        // Save and restore on one edge swap, since both read pre-edge values.
        shadow_d = save_n ? shadow_q : live_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live_q   <= RESET_VAL;
            shadow_q <= RESET_VAL;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign live = live_q;

endmodule

// File: rtl/regfile_ctx.sv
// Parametrised register file with shadow-bank context save/restore,
// indexed read ports with optional write bypass, and a ctrl-update pulse.
module regfile_ctx
    import regfile_pkg::*;
#(
    parameter int           W         = 8,
    parameter int           N         = 16,
    parameter int           NRD       = 2,
    parameter int           ALT_IDX   = ALT_IDX_DEF,
    parameter int           MEMD_IDX  = MEMD_IDX_DEF,
    parameter int           CTRL_IDX  = CTRL_IDX_DEF,
    parameter int           BYPASS    = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    regfile_if.slave  bus
);

    localparam int AW = clog2(N);

    if (N < N_MIN || N > N_MAX || NRD < 1 || NRD > NRD_MAX ||
        ALT_IDX < 0 || ALT_IDX >= N || MEMD_IDX < 0 || MEMD_IDX >= N ||
        CTRL_IDX < 0 || CTRL_IDX >= N || CTRL_IDX == MEMD_IDX) begin : g_bad_params
        $error("regfile_ctx: illegal parameter combination");
    end

    logic [N-1:0][W-1:0]   wdata;
    logic [N-1:0][W-1:0]   live;
    logic [NRD-1:0][W-1:0] rdata_c;
    raddr_t                ra_ext [NRD];
    logic                  ctrl_upd_q, ctrl_upd_d;

    for (genvar i = 0; i < N; i++) begin : g_reg
        if (i == ALT_IDX) begin : g_alt_src
            assign wdata[i] = bus.alt_d;
        end else begin : g_main_src
            assign wdata[i] = bus.d;
        end

        regfile_cell #(
            .W         (W),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_n      (bus.en_n[i]),
            .wdata     (wdata[i]),
            .save_n    (bus.save_n),
            .restore_n (bus.restore_n),
            .live      (live[i])
        );
    end

    for (genvar p = 0; p < NRD; p++) begin : g_raddr
        assign ra_ext[p] = raddr_t'(bus.raddr[p]);
    end

    // Bypass forwards write data only; a restore is visible one cycle later.
    always_comb begin
        rdata_c = '0;
        for (int p = 0; p < NRD; p++) begin
            if (ra_ext[p] < raddr_t'(N)) begin
                if (BYPASS != 0 && rst_n && !bus.en_n[bus.raddr[p]]) begin
                    rdata_c[p] = wdata[bus.raddr[p]];
                end else begin
                    rdata_c[p] = live[bus.raddr[p]];
                end
            end
        end
    end

    always_comb begin
        ctrl_upd_d = !bus.en_n[CTRL_IDX] || !bus.restore_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_upd_q <= 1'b0;
        end else begin
            ctrl_upd_q <= ctrl_upd_d;
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.q        = live;
    assign bus.ctrl     = live[CTRL_IDX];
    assign bus.memd_top = live[MEMD_IDX];
    assign bus.ctrl_upd = ctrl_upd_q;

endmodule

// File: doc/regfile_ctx.md
Name: regfile_ctx

Overview:
Parametrised general-purpose register file, the successor to the fixed 16x8 bank. It generalises register width, register count, read-port count and special-register placement. It adds synchronous reset, indexed read ports with optional write bypass, a one-level shadow bank for context save/restore, and a ctrl-update pulse. It sits between the datapath result bus/multiplier and the ALU operand muxes, control decoder and memory-data path.

Parameters:
W, 8, register width in bits
N, 16, number of registers (2..64)
NRD, 2, number of indexed read ports (1..4)
ALT_IDX, 11, register loaded from alt_d instead of d (multiplier high byte)
MEMD_IDX, 12, register driven on memd_top
CTRL_IDX, 13, register driven on ctrl; must differ from MEMD_IDX
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = registered value only
RESET_VAL, 0, reset/initial value of every live and shadow register (W bits)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
d  in  W  write data for every register except ALT_IDX
alt_d  in  W  write data for register ALT_IDX
en_n  in  N  per-register active-low write enable; any combination may be low
raddr  in  NRD x clog2(N)  read-port addresses
rdata  out  NRD x W  read-port data
q  out  N x W  live value of every register
ctrl  out  W  live value of register CTRL_IDX
memd_top  out  W  live value of register MEMD_IDX
save_n  in  1  active-low: copy all live registers into the shadow bank
restore_n  in  1  active-low: copy the shadow bank into the live registers
ctrl_upd  out  1  one-cycle pulse after register CTRL_IDX is loaded

Behaviour:
- Reset: the design has one clock. Reset is synchronous and active-low; rst_n=0 is sampled at the rising edge of clk.
- While rst_n=0, at each edge: all live and shadow registers <= RESET_VAL, ctrl_upd <= 0. Reset overrides every other input.
- Write, at an edge with rst_n=1: for each i with en_n[i]=0, reg[i] <= (i==ALT_IDX ? alt_d : d). Latency is 1 cycle, and q, ctrl and memd_top reflect the new value after that edge.
- Restore (restore_n=0): reg[i] <= shadow[i] for every i whose en_n[i]=1. A same-edge write beats restore per register.
- Save (save_n=0): shadow[i] <= pre-edge reg[i] for all i, so values written on the same edge are not captured.
- Save and restore on the same edge: a swap. Live gets the old shadow, shadow gets the old live, and writes still beat restore.
- q, ctrl and memd_top: purely registered outputs, with no combinational path from inputs.
- rdata[p]:
  - BYPASS=1, rst_n=1 and en_n[raddr[p]]=0: returns the data being written (d, or alt_d for ALT_IDX).
  - Otherwise: returns reg[raddr[p]].
  - raddr >= N (N not a power of two): returns 0.
  - Restore data is never bypassed.
- ctrl_upd: registered. It is 1 in the cycle after an edge where reg[CTRL_IDX] was loaded by a write or a restore, even if the value is unchanged. Otherwise 0, and 0 after reset.
- Illegal parameters (index >= N, CTRL_IDX==MEMD_IDX, N outside range) are caught by an elaboration-time assertion.

Decomposition:
- Shared package regfile_pkg:
  - default index constants (ALT/MEMD/CTRL)
  - clog2 helper
  - typedef for the read-address type
- Sub-module regfile_cell, instantiated N times. It holds one live and one shadow register and implements the write/restore/save priority. The top level handles the source mux, read ports, bypass and ctrl_upd.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with en_n=0 and d=8'hFF -> all q = 8'h00, ctrl_upd=0. Release, write d=8'h5A to reg3 -> q[3]=8'h5A next cycle.
- Alt source: d=8'h11, alt_d=8'hC3, en_n all 0 -> q[11]=8'hC3, every other q=8'h11. rdata with raddr=11 (BYPASS=1) shows 8'hC3 in the write cycle.
- Bypass: raddr[0]=5, en_n[5]=0, d=8'h7E -> rdata[0]=8'h7E in the same cycle. Rerun with BYPASS=0 -> rdata[0] shows the old value, then 8'h7E the next cycle.
- Context: load reg2=8'h22, pulse save_n, write reg2=8'h99, pulse restore_n -> q[2]=8'h22. Repeat with en_n[2]=0 and d=8'hAB on the restore edge -> q[2]=8'hAB.
- Swap: live reg4=8'h04, shadow reg4=8'h40, assert save_n and restore_n together -> q[4]=8'h40, then restore again -> 8'h04.
- ctrl_upd: write reg13=8'h81 -> ctrl=8'h81, ctrl_upd high exactly one cycle. Write the same value again -> pulse again. Write reg12 only -> no pulse, memd_top updates. Assert rst_n mid-pulse -> ctrl_upd=0.
